// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Groups every data and control signal of the ID->EX pipeline stage.
//
// Signal groups:
//   decode side    : id_valid, id_uses_rs1, id_uses_rs2, id_use_imm,
//                    id_reg_write, id_mem_read, id_rs1_addr, id_rs2_addr,
//                    id_rd_addr, id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl
//   control        : flush (squash the instruction entering EX)
//   downstream     : exmem_reg_write, exmem_rd_addr, exmem_alu_data,
//                    memwb_reg_write, memwb_rd_addr, memwb_wb_data
//   stage outputs  : stall_id, ex_valid, ex_reg_write, ex_mem_read,
//                    ex_rd_addr, rs1_data, rs2_data, ALUCtrl,
//                    ex_store_data, stall_cnt
//
// Modports:
//   master : the surrounding pipeline, drives the stage inputs
//   slave  : the id_ex_stage block itself
// ---------------------------------------------------------------------------
interface id_ex_stage_if;
    logic        id_valid;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_use_imm;
    logic        id_reg_write;
    logic        id_mem_read;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_ctrl;
    logic        flush;
    logic        exmem_reg_write;
    logic        memwb_reg_write;
    logic [4:0]  exmem_rd_addr;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] exmem_alu_data;
    logic [31:0] memwb_wb_data;
    logic        stall_id;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  ALUCtrl;
    logic [31:0] ex_store_data;
    logic [15:0] stall_cnt;

    modport master (
        output id_valid, id_uses_rs1, id_uses_rs2, id_use_imm, id_reg_write,
               id_mem_read, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
               id_rs2_data, id_imm, id_alu_ctrl, flush, exmem_reg_write,
               memwb_reg_write, exmem_rd_addr, memwb_rd_addr, exmem_alu_data,
               memwb_wb_data,
        input  stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr,
               rs1_data, rs2_data, ALUCtrl, ex_store_data, stall_cnt
    );

    modport slave (
        input  id_valid, id_uses_rs1, id_uses_rs2, id_use_imm, id_reg_write,
               id_mem_read, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data,
               id_rs2_data, id_imm, id_alu_ctrl, flush, exmem_reg_write,
               memwb_reg_write, exmem_rd_addr, memwb_rd_addr, exmem_alu_data,
               memwb_wb_data,
        output stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr,
               rs1_data, rs2_data, ALUCtrl, ex_store_data, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register with hazard detection, operand forwarding and a
// saturating stall counter.
//
// Ports:
//   clk  : sole clock, all state updates on the rising edge
//   rst  : asynchronous active-low reset, clears all state
//   bus  : id_ex_stage_if.slave, decode inputs, flush, downstream writeback
//          info, EX-stage outputs, stall_id and stall_cnt
//
// Configuration macro FORWARD_EN:
//   defined   : EX/MEM and MEM/WB results are forwarded into the EX operands;
//               decode stalls only on a load-use hazard against EX.
//   undefined : operands come straight from the pipeline register; decode
//               stalls on any match against EX or EX/MEM (MEM/WB matches are
//               resolved by register-file write-through).
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic        ex_valid_q;
    logic [4:0]  ex_rs1_addr_q;
    logic [4:0]  ex_rs2_addr_q;
    logic [31:0] ex_rs1_data_q;
    logic [31:0] ex_rs2_data_q;
    logic [31:0] ex_imm_q;
    logic        ex_use_imm_q;
    logic [3:0]  ex_alu_ctrl_q;
    logic [4:0]  ex_rd_q;
    logic        ex_reg_write_q;
    logic        ex_mem_read_q;
    logic [15:0] stall_cnt_q;

    logic        id_rs1_live;
    logic        id_rs2_live;
    logic        ex_writer;
    logic        hits_ex;
    logic        hazard;
    logic        stall;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;

    // A decode source only counts if the instruction is real, actually reads
    // that register, and the register is not x0.
    assign id_rs1_live = bus.id_valid && bus.id_uses_rs1 && (bus.id_rs1_addr != 5'd0);
    assign id_rs2_live = bus.id_valid && bus.id_uses_rs2 && (bus.id_rs2_addr != 5'd0);
    assign ex_writer   = ex_valid_q && ex_reg_write_q;
    assign hits_ex     = ex_writer &&
                         ((id_rs1_live && (bus.id_rs1_addr == ex_rd_q)) ||
                          (id_rs2_live && (bus.id_rs2_addr == ex_rd_q)));

`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded in time.
    assign hazard = hits_ex && ex_mem_read_q;

    // EX/MEM is the younger result and therefore wins over MEM/WB.
    always_comb begin
        fwd_rs1 = ex_rs1_data_q;
        if ((ex_rs1_addr_q != 5'd0) && bus.exmem_reg_write &&
            (ex_rs1_addr_q == bus.exmem_rd_addr)) begin
            fwd_rs1 = bus.exmem_alu_data;
        end else if ((ex_rs1_addr_q != 5'd0) && bus.memwb_reg_write &&
                     (ex_rs1_addr_q == bus.memwb_rd_addr)) begin
            fwd_rs1 = bus.memwb_wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = ex_rs2_data_q;
        if ((ex_rs2_addr_q != 5'd0) && bus.exmem_reg_write &&
            (ex_rs2_addr_q == bus.exmem_rd_addr)) begin
            fwd_rs2 = bus.exmem_alu_data;
        end else if ((ex_rs2_addr_q != 5'd0) && bus.memwb_reg_write &&
                     (ex_rs2_addr_q == bus.memwb_rd_addr)) begin
            fwd_rs2 = bus.memwb_wb_data;
        end
    end
`else
    logic hits_exmem;
    logic unused_fwd_inputs;

    assign hits_exmem = bus.exmem_reg_write &&
                        ((id_rs1_live && (bus.id_rs1_addr == bus.exmem_rd_addr)) ||
                         (id_rs2_live && (bus.id_rs2_addr == bus.exmem_rd_addr)));
    assign hazard     = hits_ex || hits_exmem;
    assign fwd_rs1    = ex_rs1_data_q;
    assign fwd_rs2    = ex_rs2_data_q;

    // Results and MEM/WB info are only needed when forwarding is built in.
    assign unused_fwd_inputs = ^{bus.exmem_alu_data, bus.memwb_reg_write,
                                 bus.memwb_rd_addr, bus.memwb_wb_data,
                                 ex_rs1_addr_q, ex_rs2_addr_q};
`endif

    // A flush squashes the entering instruction anyway, so never stall on it.
    assign stall = hazard && !bus.flush;

    // Pipeline register and stall counter. A bubble clears only the
    // qualifiers; the remaining fields keep their previous contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_addr_q  <= 5'd0;
            ex_rs2_addr_q  <= 5'd0;
            ex_rs1_data_q  <= 32'd0;
            ex_rs2_data_q  <= 32'd0;
            ex_imm_q       <= 32'd0;
            ex_use_imm_q   <= 1'b0;
            ex_alu_ctrl_q  <= 4'd0;
            ex_rd_q        <= 5'd0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            stall_cnt_q    <= 16'd0;
        end else begin
            if (bus.flush || stall) begin
                ex_valid_q     <= 1'b0;
                ex_reg_write_q <= 1'b0;
                ex_mem_read_q  <= 1'b0;
            end else begin
                ex_valid_q     <= bus.id_valid;
                ex_rs1_addr_q  <= bus.id_rs1_addr;
                ex_rs2_addr_q  <= bus.id_rs2_addr;
                ex_rs1_data_q  <= bus.id_rs1_data;
                ex_rs2_data_q  <= bus.id_rs2_data;
                ex_imm_q       <= bus.id_imm;
                ex_use_imm_q   <= bus.id_use_imm;
                ex_alu_ctrl_q  <= bus.id_alu_ctrl;
                ex_rd_q        <= bus.id_rd_addr;
                ex_reg_write_q <= bus.id_reg_write;
                ex_mem_read_q  <= bus.id_mem_read;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall_id      = stall;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_rd_addr    = ex_rd_q;
    assign bus.rs1_data      = fwd_rs1;
    assign bus.rs2_data      = ex_use_imm_q ? ex_imm_q : fwd_rs2;
    assign bus.ALUCtrl       = ex_alu_ctrl_q;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule
